// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file writeback path.
// Ports: none (package only).
// Defines address/data widths, the register count, the write request and the age stamp width.
package regfile_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 16;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;

  // The stamp is a free-running edge counter. A buffered entry never waits
  // more than two cycles, so three bits are enough to order any two live
  // entries without wrap ambiguity.
  localparam int AGE_WIDTH = 3;

  // Register 0 is hard-wired to zero, so writes to it are discarded.
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file.
// master: requesters and register file (drive requests, receive write port).
// slave: the arbiter (accepts requests, drives the registered write port).
interface regfile_write_arbiter_if #(
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_reg;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_reg;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] reg_write;
  logic [DATA_WIDTH-1:0] data_write;

  modport master (
    output req0_valid, req0_reg, req0_data, input req0_ready,
    output req1_valid, req1_reg, req1_data, input req1_ready,
    input  write_enable, reg_write, data_write
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data, output req0_ready,
    input  req1_valid, req1_reg, req1_data, output req1_ready,
    output write_enable, reg_write, data_write
  );
endinterface

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// One-entry writeback holding buffer with register-0 discard.
// Latency: captures on the accept edge; entry visible to the arbiter the next cycle.
// Backpressure: ready = !full, independent of valid; clears on the grant edge.
// Ports: valid/wr_reg/wr_data/ready handshake in; grant clears; full/buf_* out; drop pulses on a reg-0 accept.
module wb_hold_buffer
  import regfile_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [AW-1:0]        wr_reg,
  input  logic [DW-1:0]        wr_data,
  output logic                 ready,
  input  logic [AGE_WIDTH-1:0] stamp_now,
  input  logic                 grant,
  output logic                 full,
  output logic [AW-1:0]        buf_reg,
  output logic [DW-1:0]        buf_data,
  output logic [AGE_WIDTH-1:0] buf_stamp,
  output logic                 drop
);

  logic accept;

  assign ready  = !full;
  assign accept = valid && !full;
  // A reg-0 write completes the handshake but never occupies the buffer.
  assign drop   = accept && (wr_reg == '0);

  // Accept and grant are mutually exclusive: accept needs !full, grant needs full.
  always_ff @(posedge clk) begin
    if (reset) begin
      full      <= 1'b0;
      buf_reg   <= '0;
      buf_data  <= '0;
      buf_stamp <= '0;
    end else if (accept && !drop) begin
      full      <= 1'b1;
      buf_reg   <= wr_reg;
      buf_data  <= wr_data;
      buf_stamp <= stamp_now;
    end else if (grant) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (req0) and load (req1) writeback.
// Latency: accept at edge N, write port driven after edge N+1; one write per cycle.
// Backpressure: each requester stalls only while its own one-entry buffer is full.
// Ports: clk/reset; bus (slave) carries both request handshakes and the write port;
// pending_mask flags registers with outstanding writes; write_count/drop_count saturate.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = regfile_pkg::CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  regfile_write_arbiter_if.slave       bus,
  output logic [(1<<ADDR_WIDTH)-1:0]   pending_mask,
  output logic [CNT_WIDTH-1:0]         write_count,
  output logic [CNT_WIDTH-1:0]         drop_count
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  function automatic logic [NREGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] r);
    logic [NREGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  logic [AGE_WIDTH-1:0]  age_ctr;
  logic                  full0, full1, drop0, drop1, grant0, grant1;
  logic [ADDR_WIDTH-1:0] breg0, breg1;
  logic [DATA_WIDTH-1:0] bdata0, bdata1;
  logic [AGE_WIDTH-1:0]  stamp0, stamp1, age_diff;
  logic                  rr_ptr, rr_toggle;
  logic [CNT_WIDTH:0]    drop_sum;

  wb_hold_buffer #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_buf0 (
    .clk(clk), .reset(reset),
    .valid(bus.req0_valid), .wr_reg(bus.req0_reg), .wr_data(bus.req0_data),
    .ready(bus.req0_ready), .stamp_now(age_ctr), .grant(grant0),
    .full(full0), .buf_reg(breg0), .buf_data(bdata0), .buf_stamp(stamp0), .drop(drop0)
  );

  wb_hold_buffer #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_buf1 (
    .clk(clk), .reset(reset),
    .valid(bus.req1_valid), .wr_reg(bus.req1_reg), .wr_data(bus.req1_data),
    .ready(bus.req1_ready), .stamp_now(age_ctr), .grant(grant1),
    .full(full1), .buf_reg(breg1), .buf_data(bdata1), .buf_stamp(stamp1), .drop(drop1)
  );

  // Age-then-round-robin grant. A positive stamp difference (MSB clear)
  // means buf1 was stamped later, so buf0 is older.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    rr_toggle = 1'b0;
    age_diff  = stamp1 - stamp0;
    if (full0 && full1) begin
      if (age_diff == '0) begin
        if (breg0 == breg1) begin
          // Same-edge writes to one register: load value must land last.
          grant0 = 1'b1;
        end else begin
          rr_toggle = 1'b1;
          grant0    = !rr_ptr;
          grant1    = rr_ptr;
        end
      end else if (!age_diff[AGE_WIDTH-1]) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = full0;
      grant1 = full1;
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_count} + (CNT_WIDTH+1)'(drop0) + (CNT_WIDTH+1)'(drop1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      age_ctr          <= '0;
      rr_ptr           <= 1'b0;
      bus.write_enable <= 1'b0;
      bus.reg_write    <= '0;
      bus.data_write   <= '0;
      write_count      <= '0;
      drop_count       <= '0;
    end else begin
      age_ctr <= age_ctr + 1'b1;
      if (rr_toggle) rr_ptr <= !rr_ptr;
      if (grant0) begin
        bus.write_enable <= 1'b1;
        bus.reg_write    <= breg0;
        bus.data_write   <= bdata0;
      end else if (grant1) begin
        bus.write_enable <= 1'b1;
        bus.reg_write    <= breg1;
        bus.data_write   <= bdata1;
      end else begin
        bus.write_enable <= 1'b0;
      end
      if (bus.write_enable && (write_count != '1)) write_count <= write_count + 1'b1;
      drop_count <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end

  // Bit 0 can never be pending; masked explicitly so decode never stalls on r0.
  always_comb begin
    pending_mask = '0;
    if (full0)            pending_mask = pending_mask | onehot(breg0);
    if (full1)            pending_mask = pending_mask | onehot(breg1);
    if (bus.write_enable) pending_mask = pending_mask | onehot(bus.reg_write);
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_REGS-1:0]   pending_mask;
  logic [CNT_WIDTH-1:0]  write_count, drop_count;
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pending_mask(pending_mask), .write_count(write_count), .drop_count(drop_count)
  );

  // Register file model fed by the write port.
  always_ff @(posedge clk) begin
    if (bus.write_enable) rf[bus.reg_write] <= bus.data_write;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input wr_req_t w);
    bus.req0_valid = v;
    bus.req0_reg   = w.reg_addr;
    bus.req0_data  = w.data;
  endtask

  task automatic drive1(input logic v, input wr_req_t w);
    bus.req1_valid = v;
    bus.req1_reg   = w.reg_addr;
    bus.req1_data  = w.data;
  endtask

  function automatic logic [31:0] bit_of(input int r);
    logic [31:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    drive0(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    drive1(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    step();
    step();
    reset = 1'b0;
    chk("rst_ready0", 32'(bus.req0_ready), 32'd1);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd1);
    chk("rst_we", 32'(bus.write_enable), 32'd0);
    chk("rst_reg", 32'(bus.reg_write), 32'd0);
    chk("rst_data", bus.data_write, 32'd0);
    chk("rst_pending", pending_mask, 32'd0);
    chk("rst_wcnt", 32'(write_count), 32'd0);
    chk("rst_dcnt", 32'(drop_count), 32'd0);

    // 1: single ALU write reg5=0x11
    drive0(1'b1, '{reg_addr: 5'd5, data: 32'h11});
    step();
    drive0(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    chk("t1_ready0_full", 32'(bus.req0_ready), 32'd0);
    chk("t1_pend_buf", pending_mask, bit_of(5));
    chk("t1_we_early", 32'(bus.write_enable), 32'd0);
    step();
    chk("t1_we", 32'(bus.write_enable), 32'd1);
    chk("t1_reg", 32'(bus.reg_write), 32'd5);
    chk("t1_data", bus.data_write, 32'h11);
    chk("t1_pend_out", pending_mask, bit_of(5));
    chk("t1_ready0_refill", 32'(bus.req0_ready), 32'd1);
    step();
    chk("t1_we_off", 32'(bus.write_enable), 32'd0);
    chk("t1_pend_clear", pending_mask, 32'd0);
    chk("t1_reg_hold", 32'(bus.reg_write), 32'd5);
    chk("t1_wcnt", 32'(write_count), 32'd1);

    // 2: round-robin ties, rr_ptr starts at 0
    drive0(1'b1, '{reg_addr: 5'd3, data: 32'hA});
    drive1(1'b1, '{reg_addr: 5'd7, data: 32'hB});
    step();
    drive0(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    drive1(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    chk("t2_pend_both", pending_mask, bit_of(3) | bit_of(7));
    step();
    chk("t2a_first_reg", 32'(bus.reg_write), 32'd3);
    chk("t2a_first_data", bus.data_write, 32'hA);
    chk("t2a_pend", pending_mask, bit_of(3) | bit_of(7));
    step();
    chk("t2a_second_we", 32'(bus.write_enable), 32'd1);
    chk("t2a_second_reg", 32'(bus.reg_write), 32'd7);
    chk("t2a_second_data", bus.data_write, 32'hB);
    drive0(1'b1, '{reg_addr: 5'd3, data: 32'hA});
    drive1(1'b1, '{reg_addr: 5'd7, data: 32'hB});
    step();
    drive0(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    drive1(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    step();
    chk("t2b_first_reg", 32'(bus.reg_write), 32'd7);
    step();
    chk("t2b_second_reg", 32'(bus.reg_write), 32'd3);
    step();
    chk("t2_we_off", 32'(bus.write_enable), 32'd0);
    // one write from test 1 plus four here
    chk("t2_wcnt", 32'(write_count), 32'd5);

    // 3: same-edge tie on reg9, load value must be final
    drive0(1'b1, '{reg_addr: 5'd9, data: 32'h1});
    drive1(1'b1, '{reg_addr: 5'd9, data: 32'h2});
    step();
    drive0(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    drive1(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    step();
    chk("t3_first_data", bus.data_write, 32'h1);
    step();
    chk("t3_second_data", bus.data_write, 32'h2);
    step();
    chk("t3_rf9", rf[9], 32'h2);
    chk("t3_pend_clear", pending_mask, 32'd0);

    // 4: req1 older than req0
    drive1(1'b1, '{reg_addr: 5'd4, data: 32'h44});
    step();
    drive1(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    drive0(1'b1, '{reg_addr: 5'd6, data: 32'h66});
    step();
    drive0(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    chk("t4_first_reg", 32'(bus.reg_write), 32'd4);
    chk("t4_first_data", bus.data_write, 32'h44);
    step();
    chk("t4_second_reg", 32'(bus.reg_write), 32'd6);
    chk("t4_second_data", bus.data_write, 32'h66);
    step();
    chk("t4_wcnt", 32'(write_count), 32'd9);

    // 5: reg0 write is discarded
    chk("t5_ready0", 32'(bus.req0_ready), 32'd1);
    drive0(1'b1, '{reg_addr: 5'd0, data: 32'hFF});
    step();
    drive0(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    chk("t5_ready0_after", 32'(bus.req0_ready), 32'd1);
    chk("t5_dcnt", 32'(drop_count), 32'd1);
    chk("t5_pend", pending_mask, 32'd0);
    step();
    chk("t5_we", 32'(bus.write_enable), 32'd0);
    chk("t5_wcnt", 32'(write_count), 32'd9);

    // 6: reset while a buffer is full and the output is active
    drive0(1'b1, '{reg_addr: 5'd10, data: 32'hA0});
    drive1(1'b1, '{reg_addr: 5'd11, data: 32'hB0});
    step();
    drive0(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    drive1(1'b0, '{reg_addr: 5'd0, data: 32'h0});
    step();
    chk("t6_pre_we", 32'(bus.write_enable), 32'd1);
    chk("t6_pre_pend", pending_mask, bit_of(10) | bit_of(11));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_ready0", 32'(bus.req0_ready), 32'd1);
    chk("t6_ready1", 32'(bus.req1_ready), 32'd1);
    chk("t6_we", 32'(bus.write_enable), 32'd0);
    chk("t6_wcnt", 32'(write_count), 32'd0);
    chk("t6_dcnt", 32'(drop_count), 32'd0);
    chk("t6_pend", pending_mask, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_issue", 32'(bus.write_enable), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between two writeback requesters: requester 0 is ALU writeback and requester 1 is load/memory writeback. Each requester has a one-entry holding buffer with a valid/ready handshake. An age-then-round-robin arbiter drains the buffers into registered write_enable/reg_write/data_write outputs that connect directly to the register file. The block also exports a pending-write mask so decode can stall on registers whose writes have not yet landed.

Parameters:
ADDR_WIDTH, 5, register address width; the register count is 2**ADDR_WIDTH.
DATA_WIDTH, 32, register data width.
CNT_WIDTH, 16, width of the statistics counters.

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 (ALU) presents a write
req0_reg  input  ADDR_WIDTH  requester 0 destination register
req0_data  input  DATA_WIDTH  requester 0 write data
req0_ready  output  1  requester 0 buffer can accept
req1_valid  input  1  requester 1 (load) presents a write
req1_reg  input  ADDR_WIDTH  requester 1 destination register
req1_data  input  DATA_WIDTH  requester 1 write data
req1_ready  output  1  requester 1 buffer can accept
write_enable  output  1  to register file, registered
reg_write  output  ADDR_WIDTH  to register file, registered
data_write  output  DATA_WIDTH  to register file, registered
pending_mask  output  2**ADDR_WIDTH  bit r is set while a write to register r is buffered or on the output
write_count  output  CNT_WIDTH  writes issued, saturating
drop_count  output  CNT_WIDTH  register-0 writes discarded, saturating

Behaviour:
- Reset (synchronous, active-high) applies at the next posedge: both buffers are emptied; write_enable=0; reg_write=0; data_write=0; rr_ptr=0; write_count=0; drop_count=0. In-flight writes are discarded. reset dominates all other events in the same cycle.
- Handshake: reqN_ready = !bufN_full, with no combinational path from reqN_valid. An accept happens when valid&&ready at a posedge.
- Accept: bufN captures reg, data and age_stamp at that edge.
- Register-0 discard: an accepted write with reg==0 completes the handshake, leaves the buffer empty and increments drop_count.
- Age tracking: each full buffer records whether it was accepted before the other full buffer.
- Arbitration when both buffers are full:
  - The older entry is granted.
  - If both were accepted on the same edge, rr_ptr selects the winner, and rr_ptr toggles after each such tie.
  - Exception: on a same-edge tie with equal reg, requester 0 is always granted first, so requester 1's value is final. rr_ptr is not toggled in this case.
- Issue: the granted buffer is transferred to the outputs at the next posedge (write_enable<=1, reg_write, data_write) and that buffer clears on the same edge. If no buffer is full, write_enable<=0 and reg_write/data_write hold their previous values.
- Throughput: one write per cycle.
- Latency: accept at edge N, outputs valid after edge N+1, register file commits at edge N+2. Minimum accept-to-commit latency is 2 cycles.
- Refill: a drained buffer shows ready=1 in the cycle after the drain edge. Per-requester throughput is therefore 1 write per 2 cycles when uncontended.
- pending_mask is combinational from state: (buf0_full & onehot(buf0_reg)) | (buf1_full & onehot(buf1_reg)) | (write_enable & onehot(reg_write)). Bit 0 is always 0.
- write_count increments on each cycle that write_enable is asserted. Both counters saturate at all-ones and never wrap.
- Ordering guarantee: writes from one requester issue in acceptance order. Across requesters, an older accepted write always issues before a younger one.

Decomposition:
- Package regfile_pkg: ADDR_WIDTH, DATA_WIDTH, NUM_REGS, a write-request struct/typedef {reg, data}, and the register-0 constant.
- One natural sub-module, wb_hold_buffer, instantiated twice. It contains the one-entry buffer, the ready logic and the register-0 drop detect.
- The arbiter, output register, pending mask and counters stay in the top level.

Test Plan:
1. Reset, then req0 writes reg5=0x11 at edge 1 -> write_enable=1, reg_write=5, data_write=0x11 after edge 2; pending_mask[5]=1 across edges 1-2 and 0 after edge 3 (no other writes).
2. req0 (reg3=0xA) and req1 (reg7=0xB) accepted on the same edge -> rr_ptr=0 issues reg3 then reg7 on consecutive cycles; repeating the tie -> reg7 first; write_count=4.
3. Same-edge tie, both reg9 (req0=0x1, req1=0x2) -> issue 0x1 then 0x2; a register file read of reg9 returns 0x2.
4. req1 reg4 accepted at edge 1, req0 reg6 accepted at edge 2 -> reg4 issues before reg6 (age wins regardless of rr_ptr).
5. req0 writes reg0=0xFF -> ready handshake completes, no write_enable, drop_count=1, pending_mask=0.
6. Both buffers full and output active, then reset asserted for one edge -> after that edge both ready=1, write_enable=0, both counters=0, pending_mask=0, and no buffered write is ever issued.
